// File: rtl/bu2020_arb_pkg.sv
// Shared types and widths for the BU2020 memory arbiter slice.
package bu2020_arb_pkg;

   localparam int BU_ADDR_W = 12;
   localparam int BU_DATA_W = 16;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_IF,
      REQ_DM,
      REQ_LD
   } requester_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT
   } arb_state_t;

endpackage

// File: rtl/bu2020_arb_pick.sv
// Combinational winner select: LD > DM > IF, with IF promoted above DM once it has
// waited MAX_IF_WAIT cycles.
module bu2020_arb_pick
   import bu2020_arb_pkg::*;
#(
   parameter int MAX_IF_WAIT = 4,
   parameter int WAIT_W      = 3
) (
   input  logic              if_pend,
   input  logic              dm_pend,
   input  logic              ld_pend,
   input  logic [WAIT_W-1:0] if_wait,
   output logic [1:0]        winner
);

   localparam logic [WAIT_W-1:0] IF_WAIT_MAX = WAIT_W'(MAX_IF_WAIT);

   requester_t pick;

   always_comb begin
      pick = REQ_NONE;
      if (ld_pend)
         pick = REQ_LD;
      else if (if_pend && (if_wait == IF_WAIT_MAX))
         pick = REQ_IF;
      else if (dm_pend)
         pick = REQ_DM;
      else if (if_pend)
         pick = REQ_IF;
   end

   assign winner = pick;

endmodule

// File: rtl/bu2020_mem_arbiter.sv
// Shares one single-port synchronous memory between fetch (IF), data (DM) and loader (LD)
// ports; one access outstanding at a time, valid pulses return completion.
//
// state   | meaning
// S_IDLE  | no access in flight; winner picked and issued on the next edge
// S_GRANT | mem_en asserted for the owner (cycle N)
// S_WAIT  | read in flight, counting down to the mem_rdata return cycle
module bu2020_mem_arbiter
   import bu2020_arb_pkg::*;
#(
   parameter int READ_LAT    = 1,
   parameter int MAX_IF_WAIT = 4,
   parameter int ADDR_W      = BU_ADDR_W,
   parameter int DATA_W      = BU_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_stall,
   output logic [15:0]       conflict_cnt
);

   localparam int                WAIT_W      = $clog2(MAX_IF_WAIT + 1);
   localparam logic [WAIT_W-1:0] IF_WAIT_MAX = WAIT_W'(MAX_IF_WAIT);
   localparam logic [1:0]        LAT_INIT    = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   arb_state_t        state;
   requester_t        owner;
   requester_t        pick_who;
   logic [1:0]        pick_raw;
   logic              owner_we;
   logic              rd_done_q;
   logic              finish_now;
   logic [1:0]        lat_cnt;
   logic [WAIT_W-1:0] if_wait;
   logic [1:0]        n_req;
   logic              if_pend;
   logic              dm_pend;
   logic              ld_pend;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [DATA_W-1:0] ld_rdata_q;

   // A requester showing valid this cycle still holds its old req/addr; mask it so the
   // completed access is not issued twice.
   assign if_pend = if_req & ~if_valid;
   assign dm_pend = dm_req & ~dm_valid;
   assign ld_pend = ld_req & ~ld_valid;

   bu2020_arb_pick #(
      .MAX_IF_WAIT (MAX_IF_WAIT),
      .WAIT_W      (WAIT_W)
   ) u_pick (
      .if_pend (if_pend),
      .dm_pend (dm_pend),
      .ld_pend (ld_pend),
      .if_wait (if_wait),
      .winner  (pick_raw)
   );

   assign pick_who = requester_t'(pick_raw);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (pick_who)
         REQ_IF: sel_addr = if_addr;
         REQ_DM: begin
            sel_we    = dm_we;
            sel_addr  = dm_addr;
            sel_wdata = dm_wdata;
         end
         REQ_LD: begin
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
         end
         default: ;
      endcase
   end

   assign finish_now = ((state == S_GRANT) && (owner_we || (READ_LAT == 1))) ||
                       ((state == S_WAIT) && (lat_cnt == 2'd0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= REQ_NONE;
         owner_we   <= 1'b0;
         lat_cnt    <= 2'd0;
         rd_done_q  <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_valid   <= 1'b0;
         dm_valid   <= 1'b0;
         ld_valid   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         ld_rdata_q <= '0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         if_valid  <= finish_now && (owner == REQ_IF);
         dm_valid  <= finish_now && (owner == REQ_DM);
         ld_valid  <= finish_now && (owner == REQ_LD);
         rd_done_q <= finish_now && !owner_we;

         if (if_valid && rd_done_q) if_rdata_q <= mem_rdata;
         if (dm_valid && rd_done_q) dm_rdata_q <= mem_rdata;
         if (ld_valid && rd_done_q) ld_rdata_q <= mem_rdata;

         case (state)
            S_IDLE: begin
               if (pick_who != REQ_NONE) begin
                  state     <= S_GRANT;
                  owner     <= pick_who;
                  owner_we  <= sel_we;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
               end
            end
            S_GRANT, S_WAIT: begin
               if (finish_now)
                  state <= S_IDLE;
               else if (state == S_GRANT) begin
                  state   <= S_WAIT;
                  lat_cnt <= LAT_INIT;
               end else
                  lat_cnt <= lat_cnt - 2'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         if_wait <= '0;
      else if (!if_req || ((state == S_IDLE) && (pick_who == REQ_IF)))
         if_wait <= '0;
      else if (if_pend && (if_wait != IF_WAIT_MAX))
         if_wait <= if_wait + WAIT_W'(1);
   end

   assign n_req = {1'b0, if_req} + {1'b0, dm_req} + {1'b0, ld_req};

   always_ff @(posedge clk) begin
      if (!rst_n)
         conflict_cnt <= 16'h0000;
      else if ((n_req >= 2'd2) && (conflict_cnt != 16'hFFFF))
         conflict_cnt <= conflict_cnt + 16'h0001;
   end

   // Read data lands on mem_rdata in the valid cycle itself, so it is forwarded then and
   // held in the per-port register afterwards.
   assign if_rdata  = (if_valid && rd_done_q) ? mem_rdata : if_rdata_q;
   assign dm_rdata  = (dm_valid && rd_done_q) ? mem_rdata : dm_rdata_q;
   assign ld_rdata  = (ld_valid && rd_done_q) ? mem_rdata : ld_rdata_q;

   assign cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

   a_if_hold: assert property (@(posedge clk) disable iff (!rst_n) (if_req && !if_valid) |=> if_req);
   a_dm_hold: assert property (@(posedge clk) disable iff (!rst_n) (dm_req && !dm_valid) |=> dm_req);
   a_ld_hold: assert property (@(posedge clk) disable iff (!rst_n) (ld_req && !ld_valid) |=> ld_req);

endmodule

// File: tb/tb_bu2020_mem_arbiter.sv
// Scoreboard bench for bu2020_mem_arbiter: a READ_LAT=1 instance for the main scenarios and
// a READ_LAT=2 instance for the reset-during-read case.
module tb_bu2020_mem_arbiter;

   localparam int IF_ID = 0;
   localparam int DM_ID = 1;
   localparam int LD_ID = 2;

   localparam logic [11:0] PL_A [9] = '{12'h000, 12'h200, 12'h201, 12'h202, 12'h300,
                                        12'h301, 12'h302, 12'h400, 12'h401};
   localparam logic [15:0] PL_D [9] = '{16'hD000, 16'h1111, 16'h2222, 16'h3333, 16'hAAAA,
                                        16'hBBBB, 16'hCCCC, 16'h4444, 16'h5555};

   typedef struct {
      int          who;
      logic [15:0] data;
      bit          chk;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   sb_en    = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we, ld_req, ld_we;
   logic [11:0] if_addr, dm_addr, ld_addr, mem_addr;
   logic [15:0] dm_wdata, ld_wdata, mem_wdata, mem_rdata;
   logic [15:0] if_rdata, dm_rdata, ld_rdata, conflict_cnt;
   logic        if_valid, dm_valid, ld_valid, mem_we, mem_en, cpu_stall;

   logic        r_rst_n;
   logic        r_if_req, r_dm_req, r_dm_we, r_ld_req, r_ld_we;
   logic [11:0] r_if_addr, r_dm_addr, r_ld_addr, r_mem_addr;
   logic [15:0] r_dm_wdata, r_ld_wdata, r_mem_wdata, r_mem_rdata, r_pipe;
   logic [15:0] r_if_rdata, r_dm_rdata, r_ld_rdata, r_conflict_cnt;
   logic        r_if_valid, r_dm_valid, r_ld_valid, r_mem_we, r_mem_en, r_cpu_stall;

   logic [15:0] mem1 [4096];

   always #5 clk = ~clk;

   bu2020_mem_arbiter #(.READ_LAT(1), .MAX_IF_WAIT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_rdata(ld_rdata), .ld_valid(ld_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
      .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .conflict_cnt(conflict_cnt)
   );

   bu2020_mem_arbiter #(.READ_LAT(2), .MAX_IF_WAIT(4)) u_dut_lat2 (
      .clk(clk), .rst_n(r_rst_n),
      .if_req(r_if_req), .if_addr(r_if_addr), .if_rdata(r_if_rdata), .if_valid(r_if_valid),
      .dm_req(r_dm_req), .dm_we(r_dm_we), .dm_addr(r_dm_addr), .dm_wdata(r_dm_wdata),
      .dm_rdata(r_dm_rdata), .dm_valid(r_dm_valid),
      .ld_req(r_ld_req), .ld_we(r_ld_we), .ld_addr(r_ld_addr), .ld_wdata(r_ld_wdata),
      .ld_rdata(r_ld_rdata), .ld_valid(r_ld_valid),
      .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_we(r_mem_we), .mem_en(r_mem_en),
      .mem_rdata(r_mem_rdata), .cpu_stall(r_cpu_stall), .conflict_cnt(r_conflict_cnt)
   );

   // One-cycle synchronous memory behind the main instance.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem1[mem_addr] <= mem_wdata;
         else        mem_rdata      <= mem1[mem_addr];
      end
   end

   // Two-cycle memory behind the second instance; content is just the address.
   always @(posedge clk) begin
      if (r_mem_en && !r_mem_we) r_pipe <= {4'h0, r_mem_addr};
      r_mem_rdata <= r_pipe;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic push(input int who, input logic [15:0] d, input bit chk);
      exp_t e;
      e.who  = who;
      e.data = d;
      e.chk  = chk;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb_en && (if_valid || dm_valid || ld_valid)) begin
         int          who;
         logic [15:0] d;
         exp_t        e;
         who = if_valid ? IF_ID : (dm_valid ? DM_ID : LD_ID);
         d   = if_valid ? if_rdata : (dm_valid ? dm_rdata : ld_rdata);
         check("sb_onehot", 64'(if_valid) + 64'(dm_valid) + 64'(ld_valid), 64'd1);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected who=%0d rdata=%0h expected=none", who, d);
         end else begin
            e = sb_q.pop_front();
            check("sb_who", 64'(who), 64'(e.who));
            if (e.chk) check("sb_rdata", 64'(d), 64'(e.data));
         end
      end
   end

   task automatic wait_valid(input int who, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = (who == IF_ID) ? if_valid : ((who == DM_ID) ? dm_valid : ld_valid);
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s actual=no_valid expected=valid", nm);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drv_if(input logic [11:0] a);
      if_req  = 1'b1;
      if_addr = a;
      wait_valid(IF_ID, "if_timeout");
      if_req  = 1'b0;
   endtask

   task automatic drv_dm(input logic we, input logic [11:0] a, input logic [15:0] d);
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = d;
      wait_valid(DM_ID, "dm_timeout");
      dm_req   = 1'b0;
      dm_we    = 1'b0;
   endtask

   task automatic drv_ld(input logic we, input logic [11:0] a, input logic [15:0] d);
      ld_req   = 1'b1;
      ld_we    = we;
      ld_addr  = a;
      ld_wdata = d;
      wait_valid(LD_ID, "ld_timeout");
      ld_req   = 1'b0;
      ld_we    = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
      r_rst_n = 1'b0; r_if_req = 1'b0; r_if_addr = '0;
      r_dm_req = 1'b0; r_dm_we = 1'b0; r_dm_addr = '0; r_dm_wdata = '0;
      r_ld_req = 1'b0; r_ld_we = 1'b0; r_ld_addr = '0; r_ld_wdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
      check("rst_valid", {if_valid, dm_valid, ld_valid, cpu_stall}, 64'd0);
      check("rst_rdata", {if_rdata, dm_rdata, ld_rdata}, 64'd0);
      check("rst_conflict", 64'(conflict_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      r_rst_n = 1'b1;
      @(posedge clk);
      #1;
      sb_en = 1'b1;

      for (int i = 0; i < 9; i++) begin
         push(LD_ID, 16'h0, 1'b0);
         drv_ld(1'b1, PL_A[i], PL_D[i]);
      end

      // Single IF read: mem_en one cycle after req, data the cycle after that.
      push(IF_ID, 16'hD000, 1'b1);
      if_req = 1'b1; if_addr = 12'h000;
      @(negedge clk);
      check("if_c0_stall", 64'(cpu_stall), 64'd1);
      check("if_c0_mem_en", 64'(mem_en), 64'd0);
      @(negedge clk);
      check("if_c1_mem", {mem_en, mem_we, mem_addr}, {50'd0, 1'b1, 1'b0, 12'h000});
      check("if_c1_stall", 64'(cpu_stall), 64'd1);
      @(negedge clk);
      check("if_c2_valid", {if_valid, if_rdata}, {47'd0, 1'b1, 16'hD000});
      check("if_c2_stall", 64'(cpu_stall), 64'd0);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      repeat (2) @(negedge clk);
      check("if_rdata_hold", 64'(if_rdata), 64'hD000);
      @(posedge clk);
      #1;

      // DM write then read-back of the same address.
      push(DM_ID, 16'h0, 1'b0);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h123; dm_wdata = 16'hBEEF;
      @(negedge clk);
      @(negedge clk);
      check("wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {34'd0, 1'b1, 1'b1, 12'h123, 16'hBEEF});
      @(negedge clk);
      check("wr_valid_lat", 64'(dm_valid), 64'd1);
      check("wr_rdata_hold", 64'(dm_rdata), 64'd0);
      @(posedge clk);
      #1;
      dm_req = 1'b0; dm_we = 1'b0;
      push(DM_ID, 16'hBEEF, 1'b1);
      drv_dm(1'b0, 12'h123, 16'h0);
      check("if_rdata_untouched", 64'(if_rdata), 64'hD000);

      // All three read at once: LD, DM, IF; five cycles with two or more requests.
      pulse_reset();
      check("conflict_after_rst", 64'(conflict_cnt), 64'd0);
      push(LD_ID, 16'h1111, 1'b1);
      push(DM_ID, 16'h2222, 1'b1);
      push(IF_ID, 16'h3333, 1'b1);
      fork
         drv_ld(1'b0, 12'h200, 16'h0);
         drv_dm(1'b0, 12'h201, 16'h0);
         drv_if(12'h202);
      join
      @(negedge clk);
      check("conflict_three", 64'(conflict_cnt), 64'd5);
      @(posedge clk);
      #1;

      // DM back-to-back with IF: IF slips in on DM's valid cycle.
      push(DM_ID, 16'hAAAA, 1'b1);
      push(IF_ID, 16'h4444, 1'b1);
      push(DM_ID, 16'hBBBB, 1'b1);
      push(DM_ID, 16'hCCCC, 1'b1);
      fork
         begin
            drv_dm(1'b0, 12'h300, 16'h0);
            drv_dm(1'b0, 12'h301, 16'h0);
            drv_dm(1'b0, 12'h302, 16'h0);
         end
         drv_if(12'h400);
      join
      repeat (2) @(posedge clk);
      #1;

      // LD and DM both streaming: IF reaches the wait limit and then beats DM.
      push(LD_ID, 16'h1111, 1'b1);
      push(DM_ID, 16'hAAAA, 1'b1);
      push(LD_ID, 16'h2222, 1'b1);
      push(IF_ID, 16'h5555, 1'b1);
      push(LD_ID, 16'h3333, 1'b1);
      push(DM_ID, 16'hBBBB, 1'b1);
      push(DM_ID, 16'hCCCC, 1'b1);
      fork
         begin
            drv_ld(1'b0, 12'h200, 16'h0);
            drv_ld(1'b0, 12'h201, 16'h0);
            drv_ld(1'b0, 12'h202, 16'h0);
         end
         begin
            drv_dm(1'b0, 12'h300, 16'h0);
            drv_dm(1'b0, 12'h301, 16'h0);
            drv_dm(1'b0, 12'h302, 16'h0);
         end
         drv_if(12'h401);
      join
      repeat (2) @(negedge clk);
      check("sb_drain", 64'(sb_q.size()), 64'd0);
      sb_en = 1'b0;
      @(posedge clk);
      #1;

      // READ_LAT=2 instance: reset lands while the read is in flight.
      r_dm_req = 1'b1; r_dm_we = 1'b0; r_dm_addr = 12'h010;
      @(negedge clk);
      @(negedge clk);
      check("r_grant", {r_mem_en, r_mem_addr}, {51'd0, 1'b1, 12'h010});
      @(posedge clk);
      #1;
      r_rst_n = 1'b0;
      @(posedge clk);
      #1;
      r_dm_req = 1'b0;
      @(negedge clk);
      check("r_rst_outputs", {r_dm_valid, r_mem_en, r_conflict_cnt}, 64'd0);
      @(posedge clk);
      #1;
      r_rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (r_dm_valid) seen = 1'b1;
      end
      check("r_no_stale_valid", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      // Saturation of the conflict counter.
      pulse_reset();
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h200;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h300;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("conflict_100", 64'(conflict_cnt), 64'd100);
      repeat (65434) @(posedge clk);
      @(negedge clk);
      check("conflict_65534", 64'(conflict_cnt), 64'hFFFE);
      @(posedge clk);
      @(negedge clk);
      check("conflict_65535", 64'(conflict_cnt), 64'hFFFF);
      repeat (4465) @(posedge clk);
      @(negedge clk);
      check("conflict_70000", 64'(conflict_cnt), 64'hFFFF);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("conflict_hold", 64'(conflict_cnt), 64'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
